// File: rtl/axis_switch_nxm.sv
// rtl/axis_switch_nxm.sv - registered NxM AXI-Stream crossbar, tdest routing, per-output round-robin, packet lock
// Optional AXIS_SWITCH_DROP_EN: discard packets whose tdest >= M_COUNT and count them on drop_count.
module axis_switch_nxm #(
  parameter int S_COUNT    = 4,
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int DEST_WIDTH = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_COUNT-1:0]               s_axis_tvalid,
  input  logic [S_COUNT-1:0]               s_axis_tlast,
  input  logic [S_COUNT*DEST_WIDTH-1:0]    s_axis_tdest,
  input  logic [S_COUNT*ID_WIDTH-1:0]      s_axis_tid,
  output logic [S_COUNT-1:0]               s_axis_tready,
  output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_COUNT-1:0]               m_axis_tvalid,
  output logic [M_COUNT-1:0]               m_axis_tlast,
  output logic [M_COUNT*DEST_WIDTH-1:0]    m_axis_tdest,
  output logic [M_COUNT*ID_WIDTH-1:0]      m_axis_tid,
  input  logic [M_COUNT-1:0]               m_axis_tready
`ifdef AXIS_SWITCH_DROP_EN
  ,
  output logic [15:0]                      drop_count
`endif
);

  localparam int SEL_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t               state_q [M_COUNT];
  state_t               state_d [M_COUNT];
  logic [SEL_W-1:0]     owner_q [M_COUNT];
  logic [SEL_W-1:0]     owner_d [M_COUNT];
  logic [SEL_W-1:0]     rr_q    [M_COUNT];
  logic [SEL_W-1:0]     rr_d    [M_COUNT];
  logic [SEL_W-1:0]     gnt_idx [M_COUNT];
  logic [S_COUNT-1:0]   req     [M_COUNT];
  logic [M_COUNT-1:0]   gnt_vld;
  logic [M_COUNT-1:0]   slot_free;
  logic [M_COUNT-1:0]   acc;
  logic [S_COUNT-1:0]   drop_beat;
  logic [S_COUNT-1:0]   rdy;
  logic [DEST_WIDTH-1:0] dest_raw [S_COUNT];
  logic [DEST_WIDTH-1:0] dest_eff [S_COUNT];
  logic [S_COUNT-1:0]   oob;

`ifdef AXIS_SWITCH_DROP_EN
  logic [S_COUNT-1:0]   dropping_q;
  logic [16:0]          drop_sum;
`endif

  always_comb begin : route
    for (int i = 0; i < S_COUNT; i++) begin
      dest_raw[i] = s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH];
      oob[i]      = (32'(dest_raw[i]) >= M_COUNT);
      dest_eff[i] = oob[i] ? DEST_WIDTH'(M_COUNT-1) : dest_raw[i];
`ifdef AXIS_SWITCH_DROP_EN
      // once a packet starts dropping, its remaining beats are swallowed whatever their tdest
      drop_beat[i] = s_axis_tvalid[i] && (dropping_q[i] || oob[i]);
`else
      drop_beat[i] = 1'b0;
`endif
    end
    for (int j = 0; j < M_COUNT; j++) begin
      for (int i = 0; i < S_COUNT; i++) begin
        req[j][i] = s_axis_tvalid[i] && !drop_beat[i] && (32'(dest_eff[i]) == j);
      end
    end
  end

  always_comb begin : arbitrate
    int idx;
    idx = 0;
    for (int j = 0; j < M_COUNT; j++) begin
      state_d[j]   = state_q[j];
      owner_d[j]   = owner_q[j];
      rr_d[j]      = rr_q[j];
      gnt_vld[j]   = 1'b0;
      gnt_idx[j]   = '0;
      slot_free[j] = !m_axis_tvalid[j] || m_axis_tready[j];
      if (state_q[j] == ST_LOCKED) begin
        if (req[j][owner_q[j]]) begin
          gnt_vld[j] = 1'b1;
          gnt_idx[j] = owner_q[j];
        end
      end else begin
        for (int k = 0; k < S_COUNT; k++) begin
          idx = int'(rr_q[j]) + k;
          if (idx >= S_COUNT) idx = idx - S_COUNT;
          if (!gnt_vld[j] && req[j][idx]) begin
            gnt_vld[j] = 1'b1;
            gnt_idx[j] = SEL_W'(idx);
          end
        end
      end
      acc[j] = gnt_vld[j] && slot_free[j];
      if (acc[j]) begin
        if (s_axis_tlast[gnt_idx[j]]) begin
          state_d[j] = ST_IDLE;
          rr_d[j]    = SEL_W'((int'(gnt_idx[j]) + 1) % S_COUNT);
        end else begin
          state_d[j] = ST_LOCKED;
          owner_d[j] = gnt_idx[j];
        end
      end
    end
  end

  always_comb begin : ready
    rdy = drop_beat;
    for (int i = 0; i < S_COUNT; i++) begin
      for (int j = 0; j < M_COUNT; j++) begin
        if (gnt_vld[j] && slot_free[j] && (32'(gnt_idx[j]) == i)) rdy[i] = 1'b1;
      end
    end
    s_axis_tready = rst_n ? rdy : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= '0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= '0;
      m_axis_tdest  <= '0;
      m_axis_tid    <= '0;
      for (int j = 0; j < M_COUNT; j++) begin
        state_q[j] <= ST_IDLE;
        owner_q[j] <= '0;
        rr_q[j]    <= '0;
      end
    end else begin
      for (int j = 0; j < M_COUNT; j++) begin
        state_q[j] <= state_d[j];
        owner_q[j] <= owner_d[j];
        rr_q[j]    <= rr_d[j];
        if (acc[j]) begin
          m_axis_tvalid[j] <= 1'b1;
          m_axis_tdata[j*DATA_WIDTH +: DATA_WIDTH] <= s_axis_tdata[gnt_idx[j]*DATA_WIDTH +: DATA_WIDTH];
          m_axis_tdest[j*DEST_WIDTH +: DEST_WIDTH] <= s_axis_tdest[gnt_idx[j]*DEST_WIDTH +: DEST_WIDTH];
          m_axis_tid[j*ID_WIDTH +: ID_WIDTH]       <= s_axis_tid[gnt_idx[j]*ID_WIDTH +: ID_WIDTH];
          m_axis_tlast[j] <= s_axis_tlast[gnt_idx[j]];
        end else if (m_axis_tready[j]) begin
          m_axis_tvalid[j] <= 1'b0;
        end
      end
    end
  end

`ifdef AXIS_SWITCH_DROP_EN
  always_comb begin
    drop_sum = {1'b0, drop_count};
    for (int i = 0; i < S_COUNT; i++) begin
      if (drop_beat[i] && s_axis_tlast[i]) drop_sum = drop_sum + 17'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropping_q <= '0;
      drop_count <= '0;
    end else begin
      for (int i = 0; i < S_COUNT; i++) begin
        if (drop_beat[i]) dropping_q[i] <= !s_axis_tlast[i];
      end
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule
